mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 1, number of cycles the select is held before sampling; legal range 1..15.
REQ-002 Parameter CONT, default 0, continuous mode: 1 restarts the scan automatically after each accepted word.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  begin a 4-channel scan; sampled only in IDLE.
REQ-006 y_in  input  1  output of the downstream 4:1 mux being scanned.
REQ-007 s0  output  1  mux select MSB; channel index ch = {s0,s1}.
REQ-008 s1  output  1  mux select LSB; ch 00=i0, 01=i1, 10=i2, 11=i3.
REQ-009 data_out  output  4  captured word; bit[n] = value sampled on channel n.
REQ-010 valid  output  1  data_out holds a complete word awaiting acceptance.
REQ-011 ready  input  1  consumer accepts the word when valid and ready are both 1.
REQ-012 busy  output  1  1 whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have four states: IDLE, SETTLE, SAMPLE and OUT.
REQ-014 All outputs SHALL be registered: no combinational path from any input to any output.
REQ-015 In IDLE with start=1, the next state SHALL be SETTLE, with ch=0 and the settle counter loaded with SETTLE_CYC.
REQ-016 In SETTLE, the counter SHALL decrement each cycle while {s0,s1}=ch holds steady; at count 1 the next state SHALL be SAMPLE.
REQ-017 In SAMPLE, y_in SHALL be captured into internal shift bit[ch] at the clock edge that ends the cycle.
REQ-018 From SAMPLE, if ch<3 then ch SHALL increment and the next state SHALL be SETTLE with the counter reloaded.
REQ-019 From SAMPLE, if ch=3 then ch SHALL return to 0, data_out SHALL load all 4 captured bits, and the next state SHALL be OUT.
REQ-020 Each channel SHALL occupy exactly SETTLE_CYC+1 cycles.
REQ-021 If start is seen in IDLE in cycle t, valid SHALL first be 1 in cycle t+4*(SETTLE_CYC+1)+1; with the default, this is t+9.
REQ-022 In OUT, valid SHALL be 1 and data_out SHALL be stable until the cycle where valid and ready are both 1.
REQ-023 After the accept cycle, valid SHALL be 0 on the next cycle.
REQ-024 After accept, with CONT=0 the next state SHALL be IDLE.
REQ-025 After accept, with CONT=1 the next state SHALL be SETTLE with ch=0.
REQ-026 With ready held 1, the handshake SHALL complete in the first OUT cycle, so valid lasts exactly 1 cycle.
REQ-027 start asserted outside IDLE SHALL be ignored, and no request SHALL be queued.
REQ-028 ready while valid=0 SHALL be ignored.
REQ-029 data_out SHALL change only on entry to OUT and hold its last word in every other state.
REQ-030 {s0,s1} SHALL be 00 in IDLE and OUT.
REQ-031 Out-of-range SETTLE_CYC SHALL be rejected at elaboration.

Reset
REQ-032 When rst=1 at a clock edge, state SHALL become IDLE, with ch=0, s0=0, s1=0, data_out=0000, valid=0, busy=0 and the settle counter 0.
REQ-033 rst SHALL override start and ready in the same cycle.
REQ-034 Reset mid-scan or in OUT SHALL discard all partial samples and any pending word, with valid low on the cycle after the reset edge.

Verification
REQ-035 Single scan, defaults: i0..i3=1,0,1,1, start pulse in cycle 0, ready=1 -> {s0,s1} steps 00,01,10,11 at 2 cycles each; valid high for 1 cycle in cycle 9; data_out=1101.
REQ-036 Backpressure: ready=0 for 5 OUT cycles then 1 -> valid held 5+1 cycles, data_out constant, busy=1 throughout, IDLE the cycle after accept.
REQ-037 SETTLE_CYC=3, i0..i3=0,1,1,0 -> each select value held 4 cycles; valid in cycle 17; data_out=0110.
REQ-038 CONT=1, ready=1, inputs changed between scans -> back-to-back words with a new scan starting with no IDLE cycle; second word reflects the new inputs.
REQ-039 Reset in the SETTLE phase of ch=2 -> next cycle IDLE, s0=s1=0, valid=0, data_out=0000; a later start produces a full correct word.
REQ-040 start held high during a scan and ready pulsed in IDLE -> no restart mid-scan and no spurious valid; with CONT=0 and start still high after accept, a new scan begins.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - scans a 4:1 mux one channel at a time and presents the captured 4-bit word with a valid/ready handshake.
module mux_scan_ctrl #(
    parameter int SETTLE_CYC = 1,
    parameter bit CONT       = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       s0,
    output logic       s1,
    output logic [3:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("mux_scan_ctrl: SETTLE_CYC must be in 1..15");
    end

    localparam logic [3:0] LOAD = 4'(SETTLE_CYC);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, OUT} state_t;

    state_t     state, state_nx;
    logic [1:0] ch, ch_nx;
    logic [3:0] cnt, cnt_nx;
    logic [2:0] sh, sh_nx;
    logic [3:0] dout_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ch       <= 2'd0;
            cnt      <= 4'd0;
            sh       <= 3'd0;
            data_out <= 4'd0;
        end else begin
            state    <= state_nx;
            ch       <= ch_nx;
            cnt      <= cnt_nx;
            sh       <= sh_nx;
            data_out <= dout_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ch_nx    = ch;
        cnt_nx   = cnt;
        sh_nx    = sh;
        dout_nx  = data_out;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETTLE;
                    ch_nx    = 2'd0;
                    cnt_nx   = LOAD;
                end
            end
            SETTLE: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = SAMPLE;
            end
            SAMPLE: begin
                if (ch != 2'd3) begin
                    for (int i = 0; i < 3; i++)
                        if (ch == 2'(i)) sh_nx[i] = y_in;
                    ch_nx    = ch + 2'd1;
                    cnt_nx   = LOAD;
                    state_nx = SETTLE;
                end else begin
                    // Last channel goes straight into the word; sh keeps only ch0..ch2.
                    dout_nx  = {y_in, sh};
                    ch_nx    = 2'd0;
                    state_nx = OUT;
                end
            end
            OUT: begin
                if (ready) begin
                    if (CONT) begin
                        state_nx = SETTLE;
                        ch_nx    = 2'd0;
                        cnt_nx   = LOAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ch is forced to 0 whenever the FSM is in IDLE or OUT, so the selects park at 00 there.
    assign s0    = ch[1];
    assign s1    = ch[0];
    assign valid = (state == OUT);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - scoreboard bench for mux_scan_ctrl: default, slow-settle and continuous instances.
module tb_mux_scan_ctrl;

    typedef struct {
        logic [3:0] d;
        int         c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start0 = 0, ready0 = 0, s0_0, s1_0, valid0, busy0, y0;
    logic [3:0] iv0 = 0, dout0;
    logic       start1 = 0, ready1 = 0, s0_1, s1_1, valid1, busy1, y1;
    logic [3:0] iv1 = 0, dout1;
    logic       start2 = 0, ready2 = 0, s0_2, s1_2, valid2, busy2, y2;
    logic [3:0] iv2 = 0, dout2;

    // Behavioural 4:1 mux driven by each controller's selects.
    assign y0 = iv0[{s0_0, s1_0}];
    assign y1 = iv1[{s0_1, s1_1}];
    assign y2 = iv2[{s0_2, s1_2}];

    mux_scan_ctrl u0 (
        .clk(clk), .rst(rst), .start(start0), .y_in(y0), .s0(s0_0), .s1(s1_0),
        .data_out(dout0), .valid(valid0), .ready(ready0), .busy(busy0)
    );
    mux_scan_ctrl #(.SETTLE_CYC(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .y_in(y1), .s0(s0_1), .s1(s1_1),
        .data_out(dout1), .valid(valid1), .ready(ready1), .busy(busy1)
    );
    mux_scan_ctrl #(.CONT(1'b1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .y_in(y2), .s0(s0_2), .s1(s1_2),
        .data_out(dout2), .valid(valid2), .ready(ready2), .busy(busy2)
    );

    exp_t q0[$], q1[$], q2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic score(input string name, input bit have, input exp_t e, input logic [3:0] d);
        if (!have) begin
            check({name, "_spurious_valid"}, 32'd1, 32'd0);
        end else begin
            check({name, "_data"}, 32'(d), 32'(e.d));
            check({name, "_valid_cycle"}, 32'(cyc), 32'(e.c));
        end
    endtask

    // Monitor: every rising valid pops the next expected word.
    logic pv0 = 0, pv1 = 0, pv2 = 0;
    always @(negedge clk) begin
        exp_t e;
        e.d = 4'd0;
        e.c = 0;
        if (!rst) begin
            if (valid0 && !pv0) begin
                if (q0.size() > 0) begin e = q0.pop_front(); score("u0", 1, e, dout0); end
                else score("u0", 0, e, dout0);
            end
            if (valid1 && !pv1) begin
                if (q1.size() > 0) begin e = q1.pop_front(); score("u1", 1, e, dout1); end
                else score("u1", 0, e, dout1);
            end
            if (valid2 && !pv2) begin
                if (q2.size() > 0) begin e = q2.pop_front(); score("u2", 1, e, dout2); end
                else score("u2", 0, e, dout2);
            end
        end
        pv0 <= valid0;
        pv1 <= valid1;
        pv2 <= valid2;
    end

    initial begin
        int t;
        repeat (2) @(negedge clk);
        check("rst_u0", {s0_0, s1_0, valid0, busy0, dout0}, 0);
        check("rst_u1", {s0_1, s1_1, valid1, busy1, dout1}, 0);
        check("rst_u2", {s0_2, s1_2, valid2, busy2, dout2}, 0);
        rst = 0;
        @(negedge clk);

        // Single scan, i0..i3 = 1,0,1,1
        iv0 = 4'b1101; ready0 = 1; t = cyc; start0 = 1;
        q0.push_back('{4'b1101, t + 9});
        for (int k = 1; k <= 8; k++) begin
            wait_to(t + k);
            start0 = 0;
            check("t1_sel", {s0_0, s1_0}, 32'((k - 1) / 2));
            check("t1_busy", busy0, 1);
        end
        wait_to(t + 10);
        check("t1_idle", {valid0, busy0}, 0);

        // Backpressure for 5 OUT cycles
        iv0 = 4'b0010; ready0 = 0; t = cyc; start0 = 1;
        q0.push_back('{4'b0010, t + 9});
        wait_to(t + 1); start0 = 0;
        for (int k = 9; k <= 14; k++) begin
            wait_to(t + k);
            if (k == 10) iv0 = 4'b1111;
            check("t2_hold", {valid0, busy0, dout0}, {2'b11, 4'b0010});
            if (k == 14) ready0 = 1;
        end
        wait_to(t + 15);
        check("t2_after_accept", {valid0, busy0, dout0}, {2'b00, 4'b0010});

        // SETTLE_CYC=3, i0..i3 = 0,1,1,0
        iv1 = 4'b0110; ready1 = 1; t = cyc; start1 = 1;
        q1.push_back('{4'b0110, t + 17});
        for (int k = 1; k <= 16; k++) begin
            wait_to(t + k);
            start1 = 0;
            check("t3_sel", {s0_1, s1_1}, 32'((k - 1) / 4));
        end
        wait_to(t + 18);
        check("t3_idle", {valid1, busy1}, 0);

        // Continuous mode: second word from changed inputs, no IDLE gap
        iv2 = 4'b1010; ready2 = 1; t = cyc; start2 = 1;
        q2.push_back('{4'b1010, t + 9});
        q2.push_back('{4'b0101, t + 18});
        wait_to(t + 1); start2 = 0;
        wait_to(t + 9); iv2 = 4'b0101;
        wait_to(t + 10);
        check("t4_restart", {busy2, valid2, s0_2, s1_2}, 4'b1000);
        wait_to(t + 19);
        check("t4_after_second", {busy2, valid2}, 2'b10);
        rst = 1;
        wait_to(t + 20);
        rst = 0;
        check("t4_reset", {busy2, valid2, s0_2, s1_2}, 0);

        // Reset during SETTLE of ch=2, then a clean scan
        iv0 = 4'b0111; t = cyc; start0 = 1;
        wait_to(t + 1); start0 = 0;
        wait_to(t + 5);
        check("t5_in_ch2", {busy0, s0_0, s1_0}, 3'b110);
        rst = 1;
        wait_to(t + 6);
        rst = 0;
        check("t5_reset", {s0_0, s1_0, valid0, busy0, dout0}, 0);
        iv0 = 4'b1001; t = cyc; start0 = 1;
        q0.push_back('{4'b1001, t + 9});
        wait_to(t + 1); start0 = 0;
        wait_to(t + 11);

        // Ready pulsed in IDLE, then start held through a whole scan
        ready0 = 0; @(negedge clk);
        ready0 = 1; @(negedge clk);
        ready0 = 0;
        check("t6_idle_ready", {valid0, busy0}, 0);
        ready0 = 1; iv0 = 4'b1110; t = cyc; start0 = 1;
        q0.push_back('{4'b1110, t + 9});
        wait_to(t + 5);
        check("t6_no_restart", {busy0, s0_0, s1_0}, 3'b110);
        wait_to(t + 10);
        check("t6_idle_after_accept", {valid0, busy0}, 0);
        iv0 = 4'b0011;
        q0.push_back('{4'b0011, t + 19});
        wait_to(t + 11);
        start0 = 0;
        check("t6_rescan", busy0, 1);
        wait_to(t + 21);
        check("t6_done", {valid0, busy0}, 0);

        repeat (2) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
